// File: rtl/branch_resolve_pkg.sv
// Shared types and constants for the EX-stage branch resolution unit.
package branch_resolve_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] Zero = '0;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    BEQ  = 4'd1,
    BNE  = 4'd2,
    BLT  = 4'd3,
    BGE  = 4'd4,
    BLTU = 4'd5,
    BGEU = 4'd6,
    JAL  = 4'd7,
    JALR = 4'd8
  } br_t;

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cmp.sv
// Conditional-branch comparator: cond_true when the br_type compare holds.
module branch_cmp
  import branch_resolve_pkg::*;
(
  input  logic [3:0]      br_type,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (br_t'(br_type))
      BEQ:     cond_true = (rs1_val == rs2_val);
      BNE:     cond_true = (rs1_val != rs2_val);
      BLT:     cond_true = ($signed(rs1_val) <  $signed(rs2_val));
      BGE:     cond_true = ($signed(rs1_val) >= $signed(rs2_val));
      BLTU:    cond_true = (rs1_val <  rs2_val);
      BGEU:    cond_true = (rs1_val >= rs2_val);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution with misprediction redirect and wrong-path squash.
// Optional statistics counters enabled by defining BRANCH_STATS_EN.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      stall_signal,
  input  logic            valid_in,
  input  logic [3:0]      br_type,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            jump_flag,
  output logic            branch_flag,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_pc,
  output logic [XLEN-1:0] branch_to,
  output logic [XLEN-1:0] link_data,
  output logic [XLEN-1:0] stat_branches,
  output logic [XLEN-1:0] stat_mispred
);

  localparam int unsigned CNT_W = (SQUASH_DEPTH < 2) ? 1 : $clog2(SQUASH_DEPTH + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  sq_cnt_q, sq_cnt_d;
  br_t               kind;
  logic              ex_go_c, accept_c, is_jalr_c, is_jump_c, cond_true;
  logic              taken_c, mispred_c, jump_d, branch_d;
  logic [XLEN-1:0]   target_c, fall_c, next_pc_c;
  logic              unused_stall;

  assign unused_stall = ^{stall_signal[4:3], stall_signal[1:0]};

  branch_cmp u_cmp (
    .br_type   (br_type),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .cond_true (cond_true)
  );

  // Resolution datapath
  assign kind      = br_t'(br_type);
  assign ex_go_c   = valid_in && !stall_signal[2];
  assign accept_c  = ex_go_c && (state_q == IDLE) && (kind != NONE);
  assign is_jalr_c = (kind == JALR);
  assign is_jump_c = (kind == JAL) || is_jalr_c;
  assign target_c  = is_jalr_c ? ((rs1_val + imm) & ~XLEN'(1)) : (pc_in + imm);
  assign fall_c    = pc_in + XLEN'(4);
  assign taken_c   = is_jump_c || cond_true;
  assign next_pc_c = taken_c ? target_c : fall_c;
  assign mispred_c = (taken_c != pred_taken) || (taken_c && (pred_target != target_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sq_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c && mispred_c && (SQUASH_DEPTH != 0)) begin
          state_d  = SQUASH;
          sq_cnt_d = CNT_W'(SQUASH_DEPTH);
        end
      end
      SQUASH: begin
        if (ex_go_c) begin
          if (sq_cnt_q <= CNT_W'(1)) begin
            state_d  = IDLE;
            sq_cnt_d = '0;
          end else begin
            sq_cnt_d = sq_cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        sq_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    jump_d   = 1'b0;
    branch_d = 1'b0;
    if (accept_c) begin
      jump_d   = mispred_c;
      branch_d = !is_jalr_c;
    end
  end

  // Strobes pulse per accepted instruction; data outputs hold between them
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_flag    <= 1'b0;
      branch_flag  <= 1'b0;
      branch_taken <= 1'b0;
      branch_pc    <= Zero;
      branch_to    <= Zero;
      link_data    <= Zero;
    end else begin
      jump_flag   <= jump_d;
      branch_flag <= branch_d;
      if (accept_c) begin
        branch_taken <= taken_c;
        branch_pc    <= pc_in;
        branch_to    <= next_pc_c;
        link_data    <= fall_c;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= Zero;
      stat_mispred  <= Zero;
    end else begin
      if (accept_c) stat_branches <= stat_branches + XLEN'(1);
      if (jump_d)   stat_mispred  <= stat_mispred + XLEN'(1);
    end
  end
`else
  assign stat_branches = Zero;
  assign stat_mispred  = Zero;
`endif

endmodule
